// File: rtl/sad_min_search_if.sv
// Host and SAD-engine signal bundle for sad_min_search.
// master: the search controller; slave: host plus SAD engine side.
interface sad_min_search_if #(
  parameter int IDX_W = 4
);
  logic             Start;
  logic             Busy;
  logic             Done;
  logic [IDX_W-1:0] Best_Idx;
  logic [31:0]      Best_Sad;
  logic [IDX_W-1:0] Cand_Sel;
  logic             Sad_Go;
  logic             Sad_Done;
  logic [31:0]      Sad_In;

  modport master (
    input  Start, Sad_Done, Sad_In,
    output Busy, Done, Best_Idx, Best_Sad, Cand_Sel, Sad_Go
  );

  modport slave (
    output Start, Sad_Done, Sad_In,
    input  Busy, Done, Best_Idx, Best_Sad, Cand_Sel, Sad_Go
  );
endinterface

// File: rtl/sad_min_search.sv
// Best-match candidate search: issues one SAD pass per candidate and keeps the minimum.
// Optional macro SADMIN_ZERO_EXIT_EN: a zero SAD ends the search early.
module sad_min_search #(
  parameter int N_CAND = 16,
  parameter int IDX_W  = 4
) (
  input logic               Clk,
  input logic               Rst,
  sad_min_search_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_NEXT,
    S_FIN
  } state_e;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CAND - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] cand_q, cand_d;
  logic [31:0]      min_q, min_d;
  logic [IDX_W-1:0] min_idx_q, min_idx_d;
  logic [31:0]      best_sad_q, best_sad_d;
  logic [IDX_W-1:0] best_idx_q, best_idx_d;

  always_comb begin
    state_d    = state_q;
    cand_d     = cand_q;
    min_d      = min_q;
    min_idx_d  = min_idx_q;
    best_sad_d = best_sad_q;
    best_idx_d = best_idx_q;
    case (state_q)
      S_IDLE: begin
        if (bus.Start) begin
          cand_d    = '0;
          min_d     = '1;
          min_idx_d = '0;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (bus.Sad_Done) begin
          if (bus.Sad_In < min_q) begin
            min_d     = bus.Sad_In;
            min_idx_d = cand_q;
          end
`ifdef SADMIN_ZERO_EXIT_EN
          state_d = (bus.Sad_In == '0) ? S_FIN : S_NEXT;
`else
          state_d = S_NEXT;
`endif
        end
      end
      S_NEXT: begin
        if (cand_q == LAST_IDX) begin
          state_d = S_FIN;
        end else begin
          cand_d  = cand_q + 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Results are latched on entry to FIN so they are valid during the Done cycle;
    // min_d covers the zero-exit path where the minimum is captured on the same edge.
    if (state_d == S_FIN) begin
      best_sad_d = min_d;
      best_idx_d = min_idx_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= S_IDLE;
      cand_q     <= '0;
      min_q      <= '1;
      min_idx_q  <= '0;
      best_sad_q <= '0;
      best_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      cand_q     <= cand_d;
      min_q      <= min_d;
      min_idx_q  <= min_idx_d;
      best_sad_q <= best_sad_d;
      best_idx_q <= best_idx_d;
    end
  end

  assign bus.Busy     = (state_q != S_IDLE);
  assign bus.Done     = (state_q == S_FIN);
  assign bus.Sad_Go   = (state_q == S_ISSUE);
  assign bus.Cand_Sel = cand_q;
  assign bus.Best_Sad = best_sad_q;
  assign bus.Best_Idx = best_idx_q;

endmodule

// File: tb/tb_sad_min_search.sv
// Self-checking bench for sad_min_search: a SAD-engine model with random latency
// answers each Go; results are compared with a plain minimum scan of the SAD table.
module tb_sad_min_search;
  localparam int N  = 16;
  localparam int IW = 4;

  logic Clk = 1'b0;
  logic Rst;
  always #5 Clk = ~Clk;

  sad_min_search_if #(.IDX_W(IW)) bus ();

  sad_min_search #(.N_CAND(N), .IDX_W(IW)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [31:0] sad [N];
  logic [31:0] last_sad = '0;
  logic [31:0] last_idx = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic fill(input int mode);
    for (int i = 0; i < N; i++) begin
      case (mode)
        0, 2:    sad[i] = 32'(100 + 10 * i);
        1:       sad[i] = 32'd50;
        3:       sad[i] = 32'($urandom_range(0, 15));
        4:       sad[i] = $urandom;
        default: sad[i] = 32'hFFFF_FFFF;
      endcase
    end
    if (mode == 0) sad[9] = 32'd7;
    if (mode == 1) begin
      sad[3]  = 32'd5;
      sad[11] = 32'd5;
    end
    if (mode == 2) sad[4] = 32'd0;
  endtask

  task automatic do_reset(input int cycles);
    Rst = 1'b1;
    repeat (cycles) @(negedge Clk);
    Rst = 1'b0;
    last_sad = '0;
    last_idx = '0;
  endtask

  // abuse: spurious Sad_Done in ISSUE/NEXT and random Start toggling mid-search.
  // rst_at: candidate whose WAIT receives a reset (-1 for none).
  task automatic run_search(input bit abuse, input int rst_at);
    logic [31:0] exp_sad;
    int exp_idx, exp_gos;
    int gos, pend, cur, cyc;
    bit got, after_done, was_after;

    // Reference: lowest-index strict minimum, all-ones start value
    exp_sad = 32'hFFFF_FFFF;
    exp_idx = 0;
    exp_gos = N;
    for (int i = 0; i < N; i++) begin
      if (sad[i] < exp_sad) begin
        exp_sad = sad[i];
        exp_idx = i;
      end
`ifdef SADMIN_ZERO_EXIT_EN
      if (sad[i] == 32'd0) begin
        exp_gos = i + 1;
        break;
      end
`endif
    end

    check("best_idx_hold", 32'(bus.Best_Idx), last_idx);
    check("best_sad_hold", bus.Best_Sad, last_sad);

    gos = 0; pend = 0; cur = 0; cyc = 0;
    got = 1'b0; after_done = 1'b0;
    bus.Start = 1'b1;
    while (!got && cyc < 2000) begin
      @(negedge Clk);
      cyc++;
      if (cyc == 1) bus.Start = 1'b0;
      bus.Sad_Done = 1'b0;
      was_after = after_done;
      after_done = 1'b0;
      if (bus.Done) begin
        got = 1'b1;
        bus.Start = 1'b0;
      end else if (bus.Sad_Go) begin
        check("go_cand_sel", 32'(bus.Cand_Sel), 32'(gos));
        cur  = int'(bus.Cand_Sel);
        gos++;
        pend = int'($urandom_range(1, 4));
        if (rst_at == cur) begin
          @(negedge Clk);
          Rst = 1'b1;
          @(negedge Clk);
          check("rst_busy", 32'(bus.Busy), 32'd0);
          check("rst_go", 32'(bus.Sad_Go), 32'd0);
          check("rst_done", 32'(bus.Done), 32'd0);
          check("rst_best_idx", 32'(bus.Best_Idx), 32'd0);
          check("rst_best_sad", bus.Best_Sad, 32'd0);
          check("rst_cand_sel", 32'(bus.Cand_Sel), 32'd0);
          Rst = 1'b0;
          last_sad = '0;
          last_idx = '0;
          return;
        end
        if (abuse) begin
          bus.Sad_Done = 1'b1;
          bus.Sad_In   = 32'd0;
        end
      end else if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          check("wait_cand_sel", 32'(bus.Cand_Sel), 32'(cur));
          bus.Sad_Done = 1'b1;
          bus.Sad_In   = sad[cur];
          after_done   = 1'b1;
        end
      end else if (was_after && abuse) begin
        bus.Sad_Done = 1'b1;
        bus.Sad_In   = 32'd0;
      end
      if (abuse && !got) bus.Start = 1'($urandom_range(0, 1));
    end

    if (!got) begin
      check("done_timeout", 32'd0, 32'd1);
    end else begin
      check("best_idx", 32'(bus.Best_Idx), 32'(exp_idx));
      check("best_sad", bus.Best_Sad, exp_sad);
      check("go_count", 32'(gos), 32'(exp_gos));
      check("busy_at_done", 32'(bus.Busy), 32'd1);
      last_idx = 32'(exp_idx);
      last_sad = exp_sad;
      @(negedge Clk);
      check("done_width", 32'(bus.Done), 32'd0);
      check("busy_after", 32'(bus.Busy), 32'd0);
    end
    bus.Sad_Done = 1'b0;
  endtask

  initial begin
    int gos;
    bit busy_ok;
    bus.Start    = 1'b0;
    bus.Sad_Done = 1'b0;
    bus.Sad_In   = '0;
    Rst          = 1'b0;

    do_reset(2);
    check("reset_busy", 32'(bus.Busy), 32'd0);
    check("reset_done", 32'(bus.Done), 32'd0);
    check("reset_go", 32'(bus.Sad_Go), 32'd0);
    check("reset_best_idx", 32'(bus.Best_Idx), 32'd0);
    check("reset_best_sad", bus.Best_Sad, 32'd0);
    check("reset_cand_sel", 32'(bus.Cand_Sel), 32'd0);

    // Engine never answers: one Go, then a stalled WAIT
    bus.Start = 1'b1;
    @(negedge Clk);
    bus.Start = 1'b0;
    gos = 0;
    busy_ok = 1'b1;
    repeat (20) begin
      if (bus.Sad_Go) gos++;
      if (!bus.Busy) busy_ok = 1'b0;
      @(negedge Clk);
    end
    check("stall_go_count", 32'(gos), 32'd1);
    check("stall_busy", 32'(busy_ok), 32'd1);
    check("stall_cand_sel", 32'(bus.Cand_Sel), 32'd0);
    do_reset(1);

    fill(0); run_search(1'b0, -1);
    fill(1); run_search(1'b0, -1);
    fill(2); run_search(1'b0, -1);
    fill(0); run_search(1'b1, -1);
    fill(0); run_search(1'b0, 6);
    fill(3); run_search(1'b0, -1);
    fill(5); run_search(1'b0, -1);
    for (int t = 0; t < 20; t++) begin
      fill((t % 2 == 0) ? 3 : 4);
      run_search(1'($urandom_range(0, 1)), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
